// File: rtl/serial_diff_collector.sv
// serial_diff_collector
// Reassembles an LSB-first serial difference stream into a parallel word and
// presents it, with borrow and zero flags, on a one-deep valid/ready register.
// A new frame can be shifted in while the previous word waits for the consumer.

module serial_diff_collector #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             borrow_in,
    output logic [WIDTH-1:0] out_data,
    output logic             out_borrow,
    output logic             out_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             overrun
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] sr;

    logic [WIDTH-1:0] shifted;
    logic             last_bit;
    logic             slot_free;

    // Word as it will look once the current bit has been shifted in at the top.
    assign shifted = {bit_in, sr[WIDTH-1:1]};

    // The frame completes on the WIDTH-th accepted bit; a restart in the same
    // cycle always wins because it turns that bit into bit 0 of a new frame.
    assign last_bit = (state == SHIFT) && !frame_start && bit_valid &&
                      (count == CW'(WIDTH - 1));

    // The output register can take a new word if empty or being emptied now.
    assign slot_free = !out_valid || out_ready;

    assign busy = (state == SHIFT);

    // Frame collection: state, bit counter and shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
            sr    <= '0;
        end else if (frame_start) begin
            state <= SHIFT;
            if (bit_valid) begin
                sr    <= shifted;
                count <= CW'(1);
            end else begin
                count <= '0;
            end
        end else if (state == SHIFT && bit_valid) begin
            sr <= shifted;
            if (last_bit) begin
                state <= IDLE;
                count <= '0;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

    // Output register: load a finished word, retire an accepted one, or flag a drop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data   <= '0;
            out_borrow <= 1'b0;
            out_zero   <= 1'b0;
            out_valid  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (last_bit && slot_free) begin
                out_data   <= shifted;
                out_borrow <= borrow_in;
                out_zero   <= (shifted == '0);
                out_valid  <= 1'b1;
            end else begin
                if (last_bit) begin
                    overrun <= 1'b1;
                end
                if (out_valid && out_ready) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_diff_collector.sv
// tb_serial_diff_collector
// Directed bench for serial_diff_collector (WIDTH=8): reset, normal frames,
// zero/borrow flags, overrun, restart with gapped bits, and load-on-accept.

module tb_serial_diff_collector;

    logic       clk;
    logic       rst;
    logic       frame_start;
    logic       bit_in;
    logic       bit_valid;
    logic       borrow_in;
    logic [7:0] out_data;
    logic       out_borrow;
    logic       out_zero;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       overrun;

    int checksTotal;
    int checksPassed;

    serial_diff_collector #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .borrow_in   (borrow_in),
        .out_data    (out_data),
        .out_borrow  (out_borrow),
        .out_zero    (out_zero),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .busy        (busy),
        .overrun     (overrun)
    );

    // 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Guard against a run that never finishes.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drive one cycle of inputs, then sample 1 unit after the rising edge.
    task automatic applyStimulus(input logic fs, input logic bv, input logic bi,
                                 input logic bin, input logic rdy);
        frame_start = fs;
        bit_valid   = bv;
        bit_in      = bi;
        borrow_in   = bin;
        out_ready   = rdy;
        @(posedge clk);
        #1;
    endtask

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checksTotal++;
        assert (observed === expected) checksPassed++;
        else $error("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    endtask

    // frame_start cycle, then 8 consecutive bits LSB first; returns at cycle N+1.
    task automatic sendFrame(input logic [7:0] d, input logic b,
                             input logic rdyBefore, input logic rdyLast);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, rdyBefore);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b1, d[i], (i == 7) ? b : 1'b0,
                          (i == 7) ? rdyLast : rdyBefore);
        end
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        borrow_in = 1'b0;
    endtask

    // Directed test sequence.
    initial begin
        logic [7:0] c3;
        checksTotal  = 0;
        checksPassed = 0;
        rst          = 1'b1;
        frame_start  = 1'b0;
        bit_in       = 1'b0;
        bit_valid    = 1'b0;
        borrow_in    = 1'b0;
        out_ready    = 1'b0;
        c3           = 8'hC3;

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("reset_valid",   out_valid,  0);
        checkOutput("reset_data",    out_data,   0);
        checkOutput("reset_busy",    busy,       0);
        checkOutput("reset_overrun", overrun,    0);
        checkOutput("reset_zero",    out_zero,   0);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("idle_ignores_bits_busy", busy, 0);

        // Zero word with borrow, held because out_ready is low
        sendFrame(8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("zero_valid",  out_valid,  1);
        checkOutput("zero_data",   out_data,   8'h00);
        checkOutput("zero_flag",   out_zero,   1);
        checkOutput("zero_borrow", out_borrow, 1);
        checkOutput("zero_busy",   busy,       0);

        // Asynchronous reset in the middle of a frame
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("midframe_busy",  busy,      1);
        checkOutput("midframe_valid", out_valid, 1);
        bit_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_valid",  out_valid,  0);
        checkOutput("async_rst_data",   out_data,   0);
        checkOutput("async_rst_zero",   out_zero,   0);
        checkOutput("async_rst_borrow", out_borrow, 0);
        checkOutput("async_rst_busy",   busy,       0);
        #1;
        rst = 1'b0;

        // 0x5A with out_ready high: one-cycle latency, then accepted
        sendFrame(8'h5A, 1'b0, 1'b1, 1'b1);
        checkOutput("5a_valid",  out_valid,  1);
        checkOutput("5a_data",   out_data,   8'h5A);
        checkOutput("5a_borrow", out_borrow, 0);
        checkOutput("5a_zero",   out_zero,   0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("5a_accepted_valid", out_valid, 0);
        checkOutput("5a_data_holds",     out_data,  8'h5A);

        // Overrun: 0x11 held, 0x22 dropped
        sendFrame(8'h11, 1'b0, 1'b0, 1'b0);
        checkOutput("11_valid", out_valid, 1);
        checkOutput("11_data",  out_data,  8'h11);
        sendFrame(8'h22, 1'b1, 1'b0, 1'b0);
        checkOutput("overrun_pulse",  overrun,    1);
        checkOutput("overrun_data",   out_data,   8'h11);
        checkOutput("overrun_borrow", out_borrow, 0);
        checkOutput("overrun_valid",  out_valid,  1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("overrun_one_cycle", overrun,  0);
        checkOutput("overrun_held",      out_data, 8'h11);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("11_accepted_valid", out_valid, 0);

        // Gapped bits, restart after 3 bits, then 0xC3 delivered
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, c3[0], 1'b0, 1'b1);
        checkOutput("restart_no_output", out_valid, 0);
        checkOutput("restart_no_overrun", overrun,  0);
        checkOutput("restart_busy",       busy,     1);
        for (int i = 1; i < 8; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            applyStimulus(1'b0, 1'b1, c3[i], 1'b0, 1'b1);
        end
        bit_valid = 1'b0;
        checkOutput("c3_valid", out_valid, 1);
        checkOutput("c3_data",  out_data,  8'hC3);
        checkOutput("c3_busy",  busy,      0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("c3_accepted_valid", out_valid, 0);

        // Completion in the same cycle as acceptance of the held word
        sendFrame(8'h3C, 1'b0, 1'b0, 1'b0);
        checkOutput("3c_data", out_data, 8'h3C);
        sendFrame(8'hA5, 1'b1, 1'b0, 1'b1);
        checkOutput("swap_valid",   out_valid,  1);
        checkOutput("swap_data",    out_data,   8'hA5);
        checkOutput("swap_borrow",  out_borrow, 1);
        checkOutput("swap_overrun", overrun,    0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("a5_held_valid", out_valid, 1);
        checkOutput("a5_held_data",  out_data,  8'hA5);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("a5_accepted_valid", out_valid, 0);

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
